gcd_arbiter: RTL and testbench

Front-end scheduler that shares one GCD core (control unit plus subtract datapath) between two requesters. It accepts operand pairs over valid/ready channels and grants the core round-robin. It launches the core with a one-cycle go pulse, waits for done, and returns the result on the granted requester's response channel. It also short-circuits zero operands, which would never terminate in the subtract loop, and recovers a hung core with a watchdog and clear pulse.

---
 rtl/gcd_arbiter.sv | 155 +++++++++++++++
 tb/tb_gcd_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_arbiter.sv
// Round-robin front end sharing one GCD core between two requesters.
// Short-circuits zero operands and aborts a hung core with a watchdog.
module gcd_arbiter #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset_n,

  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_x,
  input  logic [WIDTH-1:0] req0_y,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_x,
  input  logic [WIDTH-1:0] req1_y,
  output logic             req1_ready,

  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp_d,
  output logic             resp_err,

  output logic [WIDTH-1:0] gcd_x,
  output logic [WIDTH-1:0] gcd_y,
  output logic             gcd_go,
  output logic             gcd_clear,
  input  logic             gcd_done,
  input  logic [WIDTH-1:0] gcd_d,

  output logic             busy
);

  localparam int unsigned WdogW = $clog2(TIMEOUT + 1);
  localparam logic [WdogW-1:0] WdogLast = WdogW'(TIMEOUT - 1);
  localparam logic [WdogW-1:0] WdogMax  = WdogW'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StLaunch, StWait, StRespond} state_e;

  state_e           state_q, state_d;
  logic             grant_q, grant_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             err_q, err_d;
  logic [WdogW-1:0] wdog_q, wdog_d;

  logic             is_idle;
  logic             pick1;
  logic             any_req;
  logic [WIDTH-1:0] sel_x;
  logic [WIDTH-1:0] sel_y;
  logic             wdog_hit;
  logic             resp_take;

  assign is_idle   = (state_q == StIdle);
  assign any_req   = req0_valid | req1_valid;
  // On a tie, the requester not served last wins.
  assign pick1     = req1_valid & (~req0_valid | ~last_q);
  assign sel_x     = pick1 ? req1_x : req0_x;
  assign sel_y     = pick1 ? req1_y : req0_y;
  assign wdog_hit  = (state_q == StWait) && (wdog_q == WdogLast);
  assign resp_take = grant_q ? resp1_ready : resp0_ready;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    x_d     = x_q;
    y_d     = y_q;
    res_d   = res_q;
    err_d   = err_q;
    wdog_d  = wdog_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          grant_d = pick1;
          x_d     = sel_x;
          y_d     = sel_y;
          if ((sel_x != '0) && (sel_y != '0)) begin
            state_d = StLaunch;
          end else begin
            // gcd(0,y)=y, gcd(x,0)=x, gcd(0,0)=0; the core would spin forever.
            res_d   = sel_x | sel_y;
            err_d   = 1'b0;
            state_d = StRespond;
          end
        end
      end
      StLaunch: begin
        wdog_d  = '0;
        state_d = StWait;
      end
      StWait: begin
        if (gcd_done) begin
          res_d   = gcd_d;
          err_d   = 1'b0;
          state_d = StRespond;
        end else if (wdog_hit) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = StRespond;
        end else if (wdog_q != WdogMax) begin
          wdog_d = wdog_q + WdogW'(1);
        end
      end
      StRespond: begin
        if (resp_take) begin
          last_d  = grant_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      x_q     <= '0;
      y_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      x_q     <= x_d;
      y_q     <= y_d;
      res_q   <= res_d;
      err_q   <= err_d;
      wdog_q  <= wdog_d;
    end
  end

  // Ready is gated by reset so nothing looks accepted while held in reset.
  assign req0_ready  = reset_n & is_idle & req0_valid & ~pick1;
  assign req1_ready  = reset_n & is_idle & pick1;
  assign resp0_valid = (state_q == StRespond) & ~grant_q;
  assign resp1_valid = (state_q == StRespond) & grant_q;
  assign resp_d      = res_q;
  assign resp_err    = err_q;
  assign gcd_x       = x_q;
  assign gcd_y       = y_q;
  assign gcd_go      = (state_q == StLaunch);
  assign gcd_clear   = wdog_hit & ~gcd_done;
  assign busy        = ~is_idle;

endmodule

// File: tb/tb_gcd_arbiter.sv
// Directed bench for gcd_arbiter with a behavioural GCD core model.
module tb_gcd_arbiter;

  logic       clk;
  logic       reset_n;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_x, req0_y, req1_x, req1_y;
  logic       req0_ready, req1_ready;
  logic       resp0_valid, resp1_valid;
  logic       resp0_ready, resp1_ready;
  logic [7:0] resp_d;
  logic       resp_err;
  logic [7:0] gcd_x, gcd_y;
  logic       gcd_go, gcd_clear, gcd_done;
  logic [7:0] gcd_d;
  logic       busy;

  int checks;
  int failures;
  int core_k;
  bit core_hang;

  logic [7:0] r_d, r_gx, r_gy;
  logic       r_err;
  int         r_lat, r_gos, r_clrs, r_clr_at;

  gcd_arbiter #(.WIDTH(8), .TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_x(req0_x), .req0_y(req0_y), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_x(req1_x), .req1_y(req1_y), .req1_ready(req1_ready),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_d(resp_d), .resp_err(resp_err),
    .gcd_x(gcd_x), .gcd_y(gcd_y), .gcd_go(gcd_go), .gcd_clear(gcd_clear),
    .gcd_done(gcd_done), .gcd_d(gcd_d), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench did not terminate");
  end

  function automatic logic [7:0] ref_gcd(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, q, t;
    p = a;
    q = b;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  // Core model: done pulses core_k cycles after the go cycle.
  initial begin
    logic [7:0] r;
    gcd_done = 1'b0;
    gcd_d    = 8'd0;
    forever begin
      @(negedge clk);
      if (gcd_go && !core_hang) begin
        r = ref_gcd(gcd_x, gcd_y);
        repeat (core_k) @(negedge clk);
        gcd_d    = r;
        gcd_done = 1'b1;
        @(negedge clk);
        gcd_done = 1'b0;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_req(input int id, input logic [7:0] x, input logic [7:0] y);
    if (id == 1) begin
      req1_valid = 1'b1; req1_x = x; req1_y = y;
    end else begin
      req0_valid = 1'b1; req0_x = x; req0_y = y;
    end
  endtask

  task automatic wait_accept(output int id);
    id = -1;
    for (int i = 0; i < 64; i++) begin
      #1;
      if (req0_ready || req1_ready) begin
        check("ready_onehot", int'(req0_ready & req1_ready), 0);
        id = req1_ready ? 1 : 0;
        break;
      end
      @(negedge clk);
    end
    if (id < 0) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_resp(input int id, input int hold);
    bit got;
    got = 1'b0;
    r_lat = 0; r_gos = 0; r_clrs = 0; r_clr_at = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      #1;
      if (gcd_go) r_gos++;
      if (gcd_clear) begin
        r_clrs++;
        r_clr_at = i;
      end
      if ((id == 1) ? resp1_valid : resp0_valid) begin
        r_lat = i;
        got   = 1'b1;
        break;
      end
    end
    if (!got) check("resp_timeout", 0, 1);
    check("resp_other_quiet", int'((id == 1) ? resp0_valid : resp1_valid), 0);
    r_d = resp_d; r_err = resp_err; r_gx = gcd_x; r_gy = gcd_y;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      #1;
      check("hold_valid", int'((id == 1) ? resp1_valid : resp0_valid), 1);
      check("hold_d", int'(resp_d), int'(r_d));
      check("hold_ready", int'(req0_ready | req1_ready), 0);
    end
    if (id == 1) resp1_ready = 1'b1; else resp0_ready = 1'b1;
    #1;
    check("no_ready_in_respond", int'(req0_ready | req1_ready), 0);
    @(posedge clk);
    #1;
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
  endtask

  typedef struct packed {
    logic       id;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] exp_d;
    logic       exp_go;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int id, n0, n1;
    vecs[0] = '{1'b0, 8'd12, 8'd18, 8'd6, 1'b1};
    vecs[1] = '{1'b1, 8'd0,  8'd9,  8'd9, 1'b0};
    vecs[2] = '{1'b1, 8'd0,  8'd0,  8'd0, 1'b0};
    vecs[3] = '{1'b0, 8'd7,  8'd0,  8'd7, 1'b0};
    vecs[4] = '{1'b1, 8'd35, 8'd14, 8'd7, 1'b1};
    vecs[5] = '{1'b0, 8'd8,  8'd12, 8'd4, 1'b1};

    checks = 0; failures = 0;
    core_k = 5; core_hang = 1'b0;
    reset_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_x = 8'd0; req0_y = 8'd0; req1_x = 8'd0; req1_y = 8'd0;
    resp0_ready = 1'b0; resp1_ready = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_go_clear", int'({gcd_go, gcd_clear}), 0);
    check("rst_resp_valid", int'({resp0_valid, resp1_valid}), 0);
    check("rst_resp", int'({resp_err, resp_d}), 0);
    check("rst_gcd_xy", int'({gcd_x, gcd_y}), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Tie: both requesters valid, expect strict alternation starting at 0.
    core_k = 2; n0 = 0; n1 = 0;
    drive_req(0, 8'd9, 8'd6);
    drive_req(1, 8'd35, 8'd14);
    for (int t = 0; t < 6; t++) begin
      wait_accept(id);
      check($sformatf("tie_grant%0d", t), id, t % 2);
      wait_resp((id == 1) ? 1 : 0, 0);
      check($sformatf("tie_d%0d", t), int'(r_d), (id == 1) ? 7 : 3);
      check($sformatf("tie_err%0d", t), int'(r_err), 0);
      if (id == 1) n1++; else n0++;
      if (n0 == 3) req0_valid = 1'b0;
      if (n1 == 3) req1_valid = 1'b0;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Single-requester vectors: core path and zero short-circuit.
    core_k = 5;
    for (int i = 0; i < 6; i++) begin
      drive_req(int'(vecs[i].id), vecs[i].x, vecs[i].y);
      wait_accept(id);
      req0_valid = 1'b0; req1_valid = 1'b0;
      check($sformatf("vec%0d_grant", i), id, int'(vecs[i].id));
      wait_resp(int'(vecs[i].id), 0);
      check($sformatf("vec%0d_d", i), int'(r_d), int'(vecs[i].exp_d));
      check($sformatf("vec%0d_err", i), int'(r_err), 0);
      check($sformatf("vec%0d_lat", i), r_lat, vecs[i].exp_go ? 2 + core_k : 1);
      check($sformatf("vec%0d_go", i), r_gos, int'(vecs[i].exp_go));
      check($sformatf("vec%0d_gx", i), int'(r_gx), int'(vecs[i].x));
      check($sformatf("vec%0d_gy", i), int'(r_gy), int'(vecs[i].y));
    end

    // Hung core: clear on the 16th WAIT cycle, error response after.
    core_hang = 1'b1;
    drive_req(0, 8'd20, 8'd8);
    wait_accept(id);
    req0_valid = 1'b0;
    wait_resp(0, 0);
    check("to_d", int'(r_d), 0);
    check("to_err", int'(r_err), 1);
    check("to_clears", r_clrs, 1);
    check("to_clear_cycle", r_clr_at, 17);
    check("to_lat", r_lat, 18);
    core_hang = 1'b0;
    drive_req(1, 8'd20, 8'd8);
    wait_accept(id);
    req1_valid = 1'b0;
    check("post_to_grant", id, 1);
    wait_resp(1, 0);
    check("post_to_d", int'(r_d), 4);
    check("post_to_err", int'(r_err), 0);

    // Response back-pressure with another request pending.
    core_k = 3;
    drive_req(0, 8'd12, 8'd18);
    wait_accept(id);
    req0_valid = 1'b0;
    drive_req(1, 8'd0, 8'd5);
    wait_resp(0, 5);
    check("bp_d", int'(r_d), 6);
    check("bp_lat", r_lat, 5);
    check("bp_next_ready", int'(req1_ready), 1);
    wait_accept(id);
    req1_valid = 1'b0;
    check("bp_next_grant", id, 1);
    wait_resp(1, 0);
    check("bp_next_d", int'(r_d), 5);
    check("bp_next_lat", r_lat, 1);

    // Reset during WAIT.
    core_hang = 1'b1;
    drive_req(0, 8'd20, 8'd8);
    wait_accept(id);
    req0_valid = 1'b0;
    repeat (4) @(negedge clk);
    drive_req(1, 8'd3, 8'd0);
    #1;
    check("pre_rst_busy", int'(busy), 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_ready", int'({req0_ready, req1_ready}), 0);
    check("mid_rst_resp_valid", int'({resp0_valid, resp1_valid}), 0);
    check("mid_rst_go_clear", int'({gcd_go, gcd_clear}), 0);
    check("mid_rst_xy", int'({gcd_x, gcd_y}), 0);
    check("mid_rst_resp", int'({resp_err, resp_d}), 0);
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    core_hang = 1'b0;
    @(negedge clk);
    #1;
    check("post_rst_idle", int'({busy, resp0_valid, resp1_valid}), 0);
    drive_req(0, 8'd8, 8'd12);
    drive_req(1, 8'd3, 8'd0);
    wait_accept(id);
    req0_valid = 1'b0;
    check("post_rst_grant", id, 0);
    wait_resp(0, 0);
    check("post_rst_d", int'(r_d), 4);
    check("post_rst_go", r_gos, 1);
    wait_accept(id);
    req1_valid = 1'b0;
    check("post_rst_grant1", id, 1);
    wait_resp(1, 0);
    check("post_rst_d1", int'(r_d), 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
